pwm_capture: RTL and testbench
==============================

// Module: pwm_capture
// PURPOSE
//  Measures period and high time of an external PWM waveform, the receive-side counterpart of the PWM generator.
//  Syncs pwm_in, detects active edges, counts prescaled ticks between them, publishes results plus a 1-cycle valid.
//  Sits in the PWM peripheral beside the generator. Results are read back through the same register file.
// PARAMETERS
//  SYNC_STAGES  2   flops in pwm_in synchronizer (>=2)
//  CNT_W        16  width of period/high counters and results
//  PSC_W        8   width of prescale
// PORTS
//  clk            in   1      main clock, all logic synchronous
//  rst            in   1      synchronous reset, active-high
//  en             in   1      capture enable (control register)
//  capture_reset  in   1      1-cycle software clear pulse
//  polarity       in   1      0: active-high pulse measured, 1: active-low (input inverted)
//  prescale       in   PSC_W  tick every prescale+1 clocks
//  pwm_in         in   1      asynchronous PWM input
//  period_val     out  CNT_W  last measured period, in ticks
//  high_val       out  CNT_W  last measured active time, in ticks
//  capture_valid  out  1      1-cycle pulse: new period_val/high_val
//  timeout        out  1      sticky: no edge within 2^CNT_W-1 ticks
//  pwm_level      out  1      synchronized, polarity-corrected level
// BEHAVIOUR
//  Reset (rst=1): all outputs 0, state IDLE, counters/prescaler 0.
//  Priority: rst > capture_reset > !en > edge/tick.
//  act = sync(pwm_in)^polarity; rise = act&~act_q; fall = ~act&act_q; pwm_level = act.
//  Prescaler psc 0..prescale, tick = en && psc==prescale. psc forced 0 on rise. prescale change applies at once, no flag.
//  FSM:
//   IDLE: enter when en=0. Counters 0, outputs hold. en=1 -> ARM.
//   ARM: wait for rise -> HIGH. Counters load 0, no valid.
//   HIGH: per_cnt, hi_cnt += tick. On fall -> LOW (hi_cnt includes fall-cycle tick).
//   LOW: per_cnt += tick. On rise: period_val <= per_cnt+tick, high_val <= hi_cnt, capture_valid=1.
//        Then counters load 0 -> HIGH.
//  First valid comes on 2nd rise after arming. Latency: valid/results update SYNC_STAGES+1 clks after first clk sampling pwm_in rise.
//  Timeout: tick while per_cnt==2^CNT_W-1 (HIGH or LOW):
//   period_val <= all-ones; high_val <= act ? all-ones : 0; capture_valid=1; timeout<=1; state ARM.
//  timeout cleared only by rst, capture_reset, or en=0.
//  capture_reset: counters, psc, period_val, high_val, timeout, valid -> 0; state ARM if en else IDLE.
//  en falling mid-measurement: no valid, partial count discarded, results hold.
//  Min resolvable active/idle phase is 1 clk post-sync; shorter glitches may be missed, no error.
//  Counters never wrap: saturation is reported only via the timeout path.
// STRUCTURE
//  pwm_defs.vh (shared with generator): FSM state localparams, default CNT_W/PSC_W.
//  Sub-module pwm_in_sync: SYNC_STAGES flops + act_q + rise/fall outputs.
//  Prescaler, counters, FSM and result regs stay in pwm_capture.
// TESTING
//  1 P=0, pol=0, pwm 10clk period/3 high: one valid per period from 2nd rise, period_val=10, high_val=3.
//  2 P=1, period 20clk/high 8: period_val=10, high_val=4.
//  3 pol=1, stimulus as test 1: period_val=10, high_val=7.
//  4 P=0, pwm_in held 1 after a rise for 70000 clks: timeout=1, period_val=high_val=16'hFFFF, one valid pulse.
//  5 capture_reset mid-HIGH after valid captures: outputs 0 next clk, no valid until two more rises, then 10/3.
//  6 rst mid-LOW: all outputs 0 next clk. en=0 mid-HIGH: no valid, values hold, next en re-arms.

Source files
------------

// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture block: FSM encoding and default widths.
package pwm_capture_pkg;

  localparam int unsigned DefSyncStages = 2;
  localparam int unsigned DefCntW       = 16;
  localparam int unsigned DefPscW       = 8;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StHigh,
    StLow
  } cap_state_e;

endpackage

// File: rtl/pwm_in_sync.sv
// Synchronizes the asynchronous PWM input, applies polarity and flags active edges.
module pwm_in_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  input  logic polarity,
  output logic act,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_q;
  logic                   prev_q;

  // Synchronizer chain, registered polarity-corrected level and its previous value.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      level_q <= sync_q[SYNC_STAGES-1] ^ polarity;
      prev_q  <= level_q;
    end
  end

  // Edge detect on the corrected level.
  always_comb begin
    act  = level_q;
    rise = level_q & ~prev_q;
    fall = ~level_q & prev_q;
  end

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period and active time of an external PWM in prescaled ticks.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DefSyncStages,
  parameter int unsigned CNT_W       = DefCntW,
  parameter int unsigned PSC_W       = DefPscW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             capture_reset,
  input  logic             polarity,
  input  logic [PSC_W-1:0] prescale,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_val,
  output logic [CNT_W-1:0] high_val,
  output logic             capture_valid,
  output logic             timeout,
  output logic             pwm_level
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  cap_state_e       state_q, state_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] pv_q, pv_d;
  logic [CNT_W-1:0] hv_q, hv_d;
  logic             valid_q, valid_d;
  logic             to_q, to_d;

  logic act, rise, fall;
  logic tick;
  logic sat;

  pwm_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .pwm_in  (pwm_in),
    .polarity(polarity),
    .act     (act),
    .rise    (rise),
    .fall    (fall)
  );

  // Tick and saturation qualifiers; saturation only matters while measuring.
  always_comb begin
    tick = en && (psc_q == prescale);
    sat  = tick && (per_q == CntMax) && ((state_q == StHigh) || (state_q == StLow));
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      psc_q   <= '0;
      per_q   <= '0;
      hi_q    <= '0;
      pv_q    <= '0;
      hv_q    <= '0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      psc_q   <= psc_d;
      per_q   <= per_d;
      hi_q    <= hi_d;
      pv_q    <= pv_d;
      hv_q    <= hv_d;
      valid_q <= valid_d;
      to_q    <= to_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (capture_reset) begin
      state_d = en ? StArm : StIdle;
    end else if (!en) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  state_d = StArm;
        StArm:   if (rise) state_d = StHigh;
        StHigh: begin
          if (sat) state_d = StArm;
          else if (fall) state_d = StLow;
        end
        StLow: begin
          if (sat) state_d = StArm;
          else if (rise) state_d = StHigh;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Prescaler, counters and result registers next values.
  always_comb begin
    psc_d   = psc_q;
    per_d   = per_q;
    hi_d    = hi_q;
    pv_d    = pv_q;
    hv_d    = hv_q;
    valid_d = 1'b0;
    to_d    = to_q;
    if (capture_reset) begin
      psc_d = '0;
      per_d = '0;
      hi_d  = '0;
      pv_d  = '0;
      hv_d  = '0;
      to_d  = 1'b0;
    end else if (!en) begin
      psc_d = '0;
      per_d = '0;
      hi_d  = '0;
      to_d  = 1'b0;
    end else begin
      // Rise realigns the prescaler; >= lets a lowered prescale take effect at once.
      if (rise || (psc_q >= prescale)) psc_d = '0;
      else psc_d = psc_q + PSC_W'(1);

      if (sat) begin
        pv_d    = CntMax;
        hv_d    = act ? CntMax : '0;
        valid_d = 1'b1;
        to_d    = 1'b1;
        per_d   = '0;
        hi_d    = '0;
      end else begin
        case (state_q)
          StHigh: begin
            per_d = per_q + CNT_W'(tick);
            hi_d  = hi_q + CNT_W'(tick);
          end
          StLow: begin
            if (rise) begin
              pv_d    = per_q + CNT_W'(tick);
              hv_d    = hi_q;
              valid_d = 1'b1;
              per_d   = '0;
              hi_d    = '0;
            end else begin
              per_d = per_q + CNT_W'(tick);
            end
          end
          default: begin
            per_d = '0;
            hi_d  = '0;
          end
        endcase
      end
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    period_val    = pv_q;
    high_val      = hv_q;
    capture_valid = valid_q;
    timeout       = to_q;
    pwm_level     = act;
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: per-cycle reference model plus directed literal checks.
module tb_pwm_capture;

  localparam int CntMax = 65535;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        capture_reset = 1'b0;
  logic        polarity = 1'b0;
  logic [7:0]  prescale = 8'd0;
  logic        pwm_in = 1'b0;
  logic [15:0] period_val;
  logic [15:0] high_val;
  logic        capture_valid;
  logic        timeout;
  logic        pwm_level;

  int n_tests = 0;
  int n_fail  = 0;
  int nvalid  = 0;
  bit chk_on  = 1'b0;

  pwm_capture #(
    .SYNC_STAGES(2),
    .CNT_W      (16),
    .PSC_W      (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .capture_reset(capture_reset),
    .polarity     (polarity),
    .prescale     (prescale),
    .pwm_in       (pwm_in),
    .period_val   (period_val),
    .high_val     (high_val),
    .capture_valid(capture_valid),
    .timeout      (timeout),
    .pwm_level    (pwm_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: the input seen by the edge logic is pwm_in delayed three clocks,
  // and measurement is described in terms of "waiting", "active" and "inactive" phases.
  int          m_mode = 0;  // 0 off, 1 waiting for first active edge, 2 active, 3 inactive
  int          m_per = 0, m_hi = 0, m_psc = 0;
  logic [15:0] m_pv = '0, m_hv = '0;
  logic        m_valid = 1'b0, m_to = 1'b0;
  logic        m_act = 1'b0, m_act_prev = 1'b0;
  logic [1:0]  m_pipe = '0;

  always @(posedge clk) begin
    logic r, f, tk, sat, nxt;
    r   = m_act && !m_act_prev;
    f   = !m_act && m_act_prev;
    tk  = en && (m_psc == int'(prescale));
    sat = tk && (m_mode >= 2) && (m_per == CntMax);
    if (rst) begin
      m_mode = 0; m_per = 0; m_hi = 0; m_psc = 0;
      m_pv = '0; m_hv = '0; m_valid = 1'b0; m_to = 1'b0;
      m_act = 1'b0; m_act_prev = 1'b0; m_pipe = '0;
    end else begin
      m_valid = 1'b0;
      if (capture_reset) begin
        m_mode = en ? 1 : 0; m_per = 0; m_hi = 0; m_psc = 0;
        m_pv = '0; m_hv = '0; m_to = 1'b0;
      end else if (!en) begin
        m_mode = 0; m_per = 0; m_hi = 0; m_psc = 0; m_to = 1'b0;
      end else begin
        m_psc = (r || m_psc >= int'(prescale)) ? 0 : m_psc + 1;
        if (sat) begin
          m_pv = 16'hFFFF; m_hv = m_act ? 16'hFFFF : 16'h0000;
          m_valid = 1'b1; m_to = 1'b1; m_mode = 1; m_per = 0; m_hi = 0;
        end else if (m_mode == 0) begin
          m_mode = 1;
        end else if (m_mode == 1) begin
          if (r) m_mode = 2;
        end else if (m_mode == 2) begin
          m_per += int'(tk); m_hi += int'(tk);
          if (f) m_mode = 3;
        end else begin
          m_per += int'(tk);
          if (r) begin
            m_pv = 16'(m_per); m_hv = 16'(m_hi); m_valid = 1'b1;
            m_per = 0; m_hi = 0; m_mode = 2;
          end
        end
      end
      nxt = m_pipe[1] ^ polarity;
      m_act_prev = m_act;
      m_act = nxt;
      m_pipe = {m_pipe[0], pwm_in};
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("period_val", period_val, m_pv);
      chk("high_val", high_val, m_hv);
      chk("capture_valid", capture_valid, m_valid);
      chk("timeout", timeout, m_to);
      chk("pwm_level", pwm_level, m_act);
      if (capture_valid) nvalid++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cycles(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_in = v;
      step();
    end
  endtask

  task automatic run_pwm(input int per, input int hi, input int n);
    for (int i = 0; i < n; i++) begin
      drive_cycles(1'b1, hi);
      drive_cycles(1'b0, per - hi);
    end
  endtask

  task automatic rearm(input logic pol, input logic [7:0] psc);
    en = 1'b0;
    drive_cycles(1'b0, 3);
    polarity = pol;
    prescale = psc;
    drive_cycles(1'b0, 4);
    en = 1'b1;
    drive_cycles(1'b0, 3);
  endtask

  initial begin
    step();
    chk_on = 1'b1;
    step();
    rst = 1'b0;
    step();

    // 1: 10 clk period, 3 active, no prescale
    rearm(1'b0, 8'd0);
    nvalid = 0;
    run_pwm(10, 3, 4);
    drive_cycles(1'b0, 4);
    chk("t1_count", nvalid, 3);
    chk("t1_period", period_val, 10);
    chk("t1_high", high_val, 3);

    // 2: prescale 1, 20 clk period, 8 active
    rearm(1'b0, 8'd1);
    nvalid = 0;
    run_pwm(20, 8, 4);
    drive_cycles(1'b0, 4);
    chk("t2_count", nvalid, 3);
    chk("t2_period", period_val, 10);
    chk("t2_high", high_val, 4);

    // 3: inverted polarity, active phase is the 7 low clocks
    rearm(1'b1, 8'd0);
    nvalid = 0;
    run_pwm(10, 3, 4);
    drive_cycles(1'b0, 4);
    chk("t3_count", nvalid, 3);
    chk("t3_period", period_val, 10);
    chk("t3_high", high_val, 7);

    // 4: input stuck active after a rise
    rearm(1'b0, 8'd0);
    nvalid = 0;
    drive_cycles(1'b1, 70000);
    chk("t4_count", nvalid, 1);
    chk("t4_period", period_val, 16'hFFFF);
    chk("t4_high", high_val, 16'hFFFF);
    chk("t4_timeout", timeout, 1);
    drive_cycles(1'b0, 6);
    chk("t4_timeout_sticky", timeout, 1);

    // 5: software clear in the middle of an active phase
    rearm(1'b0, 8'd0);
    run_pwm(10, 3, 3);
    drive_cycles(1'b1, 3);
    drive_cycles(1'b0, 2);
    capture_reset = 1'b1;
    step();
    capture_reset = 1'b0;
    @(negedge clk);
    chk("t5_clr_period", period_val, 0);
    chk("t5_clr_high", high_val, 0);
    chk("t5_clr_timeout", timeout, 0);
    drive_cycles(1'b0, 5);
    nvalid = 0;
    run_pwm(10, 3, 1);
    chk("t5_no_valid_one_rise", nvalid, 0);
    run_pwm(10, 3, 2);
    chk("t5_count", nvalid, 2);
    chk("t5_period", period_val, 10);
    chk("t5_high", high_val, 3);

    // 6a: reset in the middle of an inactive phase
    run_pwm(10, 3, 2);
    drive_cycles(1'b1, 3);
    drive_cycles(1'b0, 6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_period", period_val, 0);
    chk("t6_rst_high", high_val, 0);
    chk("t6_rst_valid", capture_valid, 0);
    chk("t6_rst_level", pwm_level, 0);

    // 6b: disable in the middle of an active phase, then re-enable
    drive_cycles(1'b0, 3);
    run_pwm(10, 3, 3);
    drive_cycles(1'b1, 3);
    drive_cycles(1'b0, 2);
    en = 1'b0;
    nvalid = 0;
    drive_cycles(1'b0, 5);
    run_pwm(10, 3, 2);
    chk("t6_en0_no_valid", nvalid, 0);
    chk("t6_en0_period_hold", period_val, 10);
    chk("t6_en0_high_hold", high_val, 3);
    en = 1'b1;
    nvalid = 0;
    run_pwm(10, 3, 3);
    drive_cycles(1'b0, 4);
    chk("t6_rearm_count", nvalid, 2);

    // Randomized segments checked by the model every cycle
    for (int seg = 0; seg < 40; seg++) begin
      int r, per, hi, n;
      r   = int'($urandom_range(0, 9));
      per = int'($urandom_range(2, 24));
      hi  = int'($urandom_range(1, per - 1));
      n   = int'($urandom_range(1, 5));
      prescale = 8'($urandom_range(0, 3));
      if (r == 0) begin
        capture_reset = 1'b1;
        step();
        capture_reset = 1'b0;
      end else if (r == 1) begin
        en = 1'b0;
        drive_cycles(pwm_in, int'($urandom_range(1, 6)));
        en = 1'b1;
      end else if (r == 2) begin
        polarity = ~polarity;
      end
      run_pwm(per, hi, n);
    end
    drive_cycles(1'b0, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
